// File: rtl/irq_pkg.sv
// Shared types for the core-side interrupt sequencer.
package irq_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Sequencer states, 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACK      = 3'd1,
      ST_REDIRECT = 3'd2,
      ST_IN_ISR   = 3'd3,
      ST_RETURN   = 3'd4
   } state_t;

endpackage

// File: rtl/irq_sequencer.sv
// Core-side interrupt sequencer: takes an interrupt at an instruction
// boundary, acknowledges it, redirects fetch to the handler and restores
// PC and global enable on MRET. One interrupt in service at a time.
module irq_sequencer
   import irq_pkg::*;
#(
   parameter int   XLEN      = XLEN_DEFAULT,
   parameter logic RESET_MIE = 1'b0,
   parameter int   CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             irq,
   input  logic [XLEN-1:0]  isr_addr,
   input  logic [XLEN-1:0]  pc_cur,
   input  logic             instr_boundary,
   input  logic             mret,
   input  logic             ie_set,
   input  logic             ie_clr,
   output logic             iack,
   output logic             stall_req,
   output logic             pc_redirect,
   output logic [XLEN-1:0]  pc_target,
   output logic             mie,
   output logic             in_isr,
   output logic [XLEN-1:0]  epc,
   output logic [CNT_W-1:0] irq_count,
   output logic             err
);

   state_t          state;
   state_t          state_next;
   logic            mpie;
   logic [XLEN-1:0] tgt;
   logic            take;

   // A clearing pulse in the same cycle suppresses the take, so software
   // that masks interrupts never sees one slip through on that edge.
   assign take = (state == ST_IDLE) & irq & mie & instr_boundary & ~ie_clr;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state decode and the state-derived pulse outputs.
   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next  = state;
      iack        = 1'b0;
      stall_req   = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = '0;
      in_isr      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (take) state_next = ST_ACK;
         end
         ST_ACK: begin
            iack       = 1'b1;
            stall_req  = 1'b1;
            state_next = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            pc_redirect = 1'b1;
            pc_target   = tgt;
            stall_req   = 1'b1;
            state_next  = ST_IN_ISR;
         end
         ST_IN_ISR: begin
            in_isr = 1'b1;
            if (mret) state_next = ST_RETURN;
         end
         ST_RETURN: begin
            pc_redirect = 1'b1;
            pc_target   = epc;
            stall_req   = 1'b1;
            in_isr      = 1'b1;
            state_next  = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Architectural state: enables, saved PC/target, counter, sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie       <= RESET_MIE;
         mpie      <= 1'b0;
         epc       <= '0;
         tgt       <= '0;
         irq_count <= '0;
         err       <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               // A spurious MRET is flagged but never blocks a pending take.
               if (mret) err <= 1'b1;
               if (take) begin
                  epc <= pc_cur;
                  tgt <= isr_addr;
               end else if (ie_clr) begin
                  mie <= 1'b0;
               end else if (ie_set) begin
                  mie <= 1'b1;
               end
            end
            ST_ACK: begin
               if (mret) err <= 1'b1;
               mpie      <= mie;
               mie       <= 1'b0;
               irq_count <= irq_count + 1'b1;
            end
            ST_REDIRECT: begin
               if (mret) err <= 1'b1;
            end
            ST_IN_ISR: begin
               // Inside the handler, enable writes target the value MRET restores.
               if (ie_clr)      mpie <= 1'b0;
               else if (ie_set) mpie <= 1'b1;
            end
            ST_RETURN: begin
               mie <= mpie;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer. Expected redirect targets are
// queued when the stimulus that causes them is driven; a negedge monitor
// pops and compares them whenever the DUT issues a redirect.
module tb_irq_sequencer;

   localparam int   XLEN      = 32;
   localparam int   CNT_W     = 8;
   localparam logic RESET_MIE = 1'b0;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             irq;
   logic [XLEN-1:0]  isr_addr;
   logic [XLEN-1:0]  pc_cur;
   logic             instr_boundary;
   logic             mret;
   logic             ie_set;
   logic             ie_clr;
   logic             iack;
   logic             stall_req;
   logic             pc_redirect;
   logic [XLEN-1:0]  pc_target;
   logic             mie;
   logic             in_isr;
   logic [XLEN-1:0]  epc;
   logic [CNT_W-1:0] irq_count;
   logic             err;

   int checks = 0;
   int errors = 0;
   logic             mon_en = 1'b0;
   logic [XLEN-1:0]  exp_q[$];
   logic [CNT_W-1:0] exp_count = '0;

   irq_sequencer #(.XLEN(XLEN), .RESET_MIE(RESET_MIE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .irq(irq), .isr_addr(isr_addr), .pc_cur(pc_cur),
      .instr_boundary(instr_boundary), .mret(mret), .ie_set(ie_set), .ie_clr(ie_clr),
      .iack(iack), .stall_req(stall_req), .pc_redirect(pc_redirect),
      .pc_target(pc_target), .mie(mie), .in_isr(in_isr), .epc(epc),
      .irq_count(irq_count), .err(err)
   );

   always #5 clk = ~clk;

   // Redirect scoreboard and idle-target monitor.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         checks++;
         if (pc_redirect) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_redirect got target %h want none", pc_target);
            end else begin
               logic [XLEN-1:0] want;
               want = exp_q.pop_front();
               if (pc_target !== want) begin
                  errors++;
                  $display("FAIL redirect_target got %h want %h", pc_target, want);
               end
            end
         end else if (pc_target !== '0) begin
            errors++;
            $display("FAIL idle_target got %h want 0", pc_target);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      irq = 0; isr_addr = '0; pc_cur = '0; instr_boundary = 0;
      mret = 0; ie_set = 0; ie_clr = 0;
   endtask

   // Full take/return from IDLE with mie=1; pulses and targets are checked.
   task automatic service(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] addr);
      irq = 1; pc_cur = pc; isr_addr = addr; instr_boundary = 1;
      exp_q.push_back(addr);
      step();
      exp_count++;
      checks++;
      if (iack !== 1'b1 || stall_req !== 1'b1) begin
         errors++;
         $display("FAIL service_iack got iack=%b stall=%b want 1 1", iack, stall_req);
      end
      irq = 0;
      step();
      step();
      mret = 1;
      exp_q.push_back(pc);
      step();
      mret = 0;
      step();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1;
      step();
      step();
      #2 rst_n = 0;
      #1;
      checks++;
      if ({iack, stall_req, pc_redirect, in_isr, err} !== 5'b0 || pc_target !== '0 ||
          epc !== '0 || irq_count !== '0 || mie !== RESET_MIE) begin
         errors++;
         $display("FAIL reset_values got iack=%b stall=%b redir=%b isr=%b err=%b tgt=%h epc=%h cnt=%0d mie=%b want zeros mie=%b",
                  iack, stall_req, pc_redirect, in_isr, err, pc_target, epc, irq_count, mie, RESET_MIE);
      end
      step();
      step();
      rst_n = 1;
      mon_en = 1;
      step();
   endtask

   task automatic test_basic_take();
      ie_set = 1;
      step();
      ie_set = 0;
      checks++;
      if (mie !== 1'b1) begin errors++; $display("FAIL ie_set_idle got mie=%b want 1", mie); end
      irq = 1; pc_cur = 32'h100; isr_addr = 32'h2040; instr_boundary = 1;
      exp_q.push_back(32'h2040);
      step();
      exp_count++;
      checks++;
      if (iack !== 1 || stall_req !== 1 || pc_redirect !== 0) begin
         errors++;
         $display("FAIL take_t1 got iack=%b stall=%b redir=%b want 1 1 0", iack, stall_req, pc_redirect);
      end
      irq = 0;
      step();
      checks++;
      if (pc_redirect !== 1 || iack !== 0 || stall_req !== 1 || epc !== 32'h100 ||
          mie !== 0 || irq_count !== exp_count) begin
         errors++;
         $display("FAIL take_t2 got redir=%b iack=%b stall=%b epc=%h mie=%b cnt=%0d want 1 0 1 100 0 %0d",
                  pc_redirect, iack, stall_req, epc, mie, irq_count, exp_count);
      end
      step();
      checks++;
      if (in_isr !== 1 || stall_req !== 0 || pc_redirect !== 0) begin
         errors++;
         $display("FAIL take_t3 got isr=%b stall=%b redir=%b want 1 0 0", in_isr, stall_req, pc_redirect);
      end
   endtask

   task automatic test_return();
      irq = 1; isr_addr = 32'h3000; pc_cur = 32'h180; instr_boundary = 1;
      ie_set = 1;
      step();
      ie_set = 0;
      step();
      step();
      checks++;
      if (mie !== 0 || iack !== 0 || in_isr !== 1) begin
         errors++;
         $display("FAIL isr_ignore_irq got mie=%b iack=%b isr=%b want 0 0 1", mie, iack, in_isr);
      end
      mret = 1;
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h3000);
      step();
      mret = 0;
      checks++;
      if (pc_redirect !== 1 || pc_target !== 32'h100 || in_isr !== 1 || mie !== 0 || stall_req !== 1) begin
         errors++;
         $display("FAIL return_m1 got redir=%b tgt=%h isr=%b mie=%b stall=%b want 1 100 1 0 1",
                  pc_redirect, pc_target, in_isr, mie, stall_req);
      end
      step();
      checks++;
      if (mie !== 1 || iack !== 0 || in_isr !== 0) begin
         errors++;
         $display("FAIL return_m2 got mie=%b iack=%b isr=%b want 1 0 0", mie, iack, in_isr);
      end
      step();
      exp_count++;
      checks++;
      if (iack !== 1 || epc !== 32'h180) begin
         errors++;
         $display("FAIL retake_m3 got iack=%b epc=%h want 1 180", iack, epc);
      end
      irq = 0;
      step();
      step();
      mret = 1;
      exp_q.push_back(32'h180);
      step();
      mret = 0;
      step();
      checks++;
      if (mie !== 1 || irq_count !== exp_count) begin
         errors++;
         $display("FAIL second_return got mie=%b cnt=%0d want 1 %0d", mie, irq_count, exp_count);
      end
   endtask

   task automatic test_masked();
      int seen;
      ie_clr = 1;
      step();
      ie_clr = 0;
      irq = 1; instr_boundary = 1; isr_addr = 32'h5000;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (iack !== 0) seen++;
      end
      checks++;
      if (seen != 0 || mie !== 0) begin
         errors++;
         $display("FAIL masked_no_iack got %0d iacks mie=%b want 0 0", seen, mie);
      end
      irq = 0; ie_set = 1;
      step();
      ie_set = 1; ie_clr = 1; irq = 1;
      step();
      ie_set = 0; ie_clr = 0;
      checks++;
      if (iack !== 0 || mie !== 0) begin
         errors++;
         $display("FAIL set_clr_block got iack=%b mie=%b want 0 0", iack, mie);
      end
      step();
      checks++;
      if (iack !== 0) begin errors++; $display("FAIL clr_stays_masked got iack=%b want 0", iack); end
      irq = 0; ie_set = 1;
      step();
      ie_set = 0; irq = 1; instr_boundary = 0;
      step();
      step();
      step();
      checks++;
      if (iack !== 0 || mie !== 1) begin
         errors++;
         $display("FAIL no_boundary got iack=%b mie=%b want 0 1", iack, mie);
      end
      irq = 0; instr_boundary = 1;
      step();
   endtask

   task automatic test_spurious_mret();
      mret = 1;
      step();
      mret = 0;
      checks++;
      if (err !== 1 || pc_redirect !== 0) begin
         errors++;
         $display("FAIL spurious_mret got err=%b redir=%b want 1 0", err, pc_redirect);
      end
      step();
      step();
      step();
      checks++;
      if (err !== 1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
      irq = 1; mret = 1; pc_cur = 32'h240; isr_addr = 32'h4000; instr_boundary = 1;
      exp_q.push_back(32'h4000);
      step();
      exp_count++;
      mret = 0; irq = 0;
      checks++;
      if (iack !== 1) begin errors++; $display("FAIL take_with_mret got iack=%b want 1", iack); end
      step();
      step();
      mret = 1;
      exp_q.push_back(32'h240);
      step();
      mret = 0;
      step();
      checks++;
      if (err !== 1 || mie !== 1 || irq_count !== exp_count) begin
         errors++;
         $display("FAIL after_spurious got err=%b mie=%b cnt=%0d want 1 1 %0d", err, mie, irq_count, exp_count);
      end
   endtask

   task automatic test_reset_mid();
      irq = 1; pc_cur = 32'h300; isr_addr = 32'h6000; instr_boundary = 1;
      step();
      irq = 0;
      step();
      #2 rst_n = 0;
      #1;
      exp_count = '0;
      checks++;
      if ({iack, stall_req, pc_redirect, in_isr, err, mie} !== 6'b0 || epc !== '0 || irq_count !== '0) begin
         errors++;
         $display("FAIL reset_mid got iack=%b stall=%b redir=%b isr=%b err=%b mie=%b epc=%h cnt=%0d want zeros",
                  iack, stall_req, pc_redirect, in_isr, err, mie, epc, irq_count);
      end
      irq = 1;
      step();
      step();
      rst_n = 1;
      step();
      checks++;
      if (iack !== 0 || pc_redirect !== 0) begin
         errors++;
         $display("FAIL post_reset_quiet got iack=%b redir=%b want 0 0", iack, pc_redirect);
      end
      ie_set = 1;
      step();
      ie_set = 0;
      checks++;
      if (iack !== 0 || mie !== 1) begin
         errors++;
         $display("FAIL post_reset_set got iack=%b mie=%b want 0 1", iack, mie);
      end
      irq = 0;
      service(32'h340, 32'h6100);
      checks++;
      if (irq_count !== exp_count || mie !== 1 || err !== 0) begin
         errors++;
         $display("FAIL post_reset_take got cnt=%0d mie=%b err=%b want %0d 1 0", irq_count, mie, err, exp_count);
      end
   endtask

   task automatic test_mret_in_ack();
      irq = 1; pc_cur = 32'h400; isr_addr = 32'h7000; instr_boundary = 1;
      exp_q.push_back(32'h7000);
      step();
      exp_count++;
      irq = 0; mret = 1;
      step();
      mret = 0;
      checks++;
      if (err !== 1 || pc_redirect !== 1 || in_isr !== 0) begin
         errors++;
         $display("FAIL mret_in_ack got err=%b redir=%b isr=%b want 1 1 0", err, pc_redirect, in_isr);
      end
      step();
      mret = 1;
      exp_q.push_back(32'h400);
      step();
      mret = 0;
      step();
   endtask

   task automatic test_count_wrap();
      while (exp_count != {CNT_W{1'b1}})
         service(32'h500, 32'h8000);
      checks++;
      if (irq_count !== {CNT_W{1'b1}}) begin
         errors++;
         $display("FAIL count_max got %0d want %0d", irq_count, {CNT_W{1'b1}});
      end
      service(32'h504, 32'h8004);
      checks++;
      if (irq_count !== '0 || exp_count !== '0) begin
         errors++;
         $display("FAIL count_wrap got %0d want 0", irq_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic_take();
      test_return();
      test_masked();
      test_spurious_mret();
      test_reset_mid();
      test_mret_in_ack();
      test_count_wrap();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_redirects got %0d outstanding want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Core-side interrupt sequencer sitting directly downstream of the interrupt controller. It samples the controller's IRQ and ISR address at an instruction boundary, saves the return PC, and returns a one-cycle IACK. It then redirects the fetch PC to the handler and, on MRET, restores the PC and the interrupt-enable state. One interrupt is in service at a time; nesting is not supported.

## Interface
Parameters:
- XLEN, 32: PC / address width
- RESET_MIE, 0: reset value of the global interrupt enable
- CNT_W, 8: width of serviced-interrupt counter

Ports (reset is asynchronous, active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- irq  in  1  level interrupt request from controller
- isr_addr  in  XLEN  handler address; valid while irq=1
- pc_cur  in  XLEN  address of next un-executed instruction
- instr_boundary  in  1  core at a commit point; safe to take interrupt
- mret  in  1  return-from-interrupt committing (1-cycle pulse)
- ie_set / ie_clr  in  1  each; global-enable set/clear pulses
- iack  out  1  acknowledge to controller, 1-cycle pulse
- stall_req  out  1  core must hold commit/fetch
- pc_redirect  out  1  load pc_target into PC, 1-cycle pulse
- pc_target  out  XLEN  redirect destination
- mie  out  1  global interrupt enable
- in_isr  out  1  handler in progress
- epc  out  XLEN  saved return PC
- irq_count  out  CNT_W  interrupts serviced; wraps
- err  out  1  sticky: MRET seen outside a handler

## Operation
- States: IDLE, ACK, REDIRECT, IN_ISR, RETURN.
- take = (state==IDLE) & irq & mie & instr_boundary & ~ie_clr.
- IDLE: on take, latch epc<=pc_cur and tgt<=isr_addr, then go to ACK. Otherwise ie_set→mie=1 and ie_clr→mie=0; ie_clr wins if both are asserted.
- ACK: iack=1 and stall_req=1. Then mpie<=mie, mie<=0, irq_count+=1, and go to REDIRECT.
- REDIRECT: pc_redirect=1, pc_target=tgt, stall_req=1. Then go to IN_ISR.
- IN_ISR: in_isr=1, and irq is ignored. ie_set/ie_clr act on mpie, not mie. On mret, go to RETURN.
- RETURN: pc_redirect=1, pc_target=epc, stall_req=1, in_isr=1. Then mie<=mpie and go to IDLE.
- mret while in IDLE:
  - err<=1 (sticky until reset); no redirect.
  - If take occurs in the same cycle, the interrupt is still taken.
- mret in ACK or REDIRECT is ignored and sets err.
- irq dropping after take has no effect, because the target is already latched.
- irq_count wraps from 2^CNT_W−1 to 0.
- pc_target = 0 when pc_redirect=0.

## Timing
- Reset (async assert, sync-released by the core): state=IDLE, mie=RESET_MIE, mpie=0, epc=0, tgt=0, irq_count=0, err=0. All pulses and stall_req are 0; in_isr=0.
- Take at cycle T:
  - T+1: iack=1.
  - T+2: pc_redirect=1.
  - T+3: IN_ISR.
- stall_req is high in T+1..T+2.
- mret at cycle M: pc_redirect=1 with pc_target=epc at M+1, and mie is restored at M+2.
- A new take is possible in the cycle following RETURN (M+2) if the take conditions hold.
- Reset asserted mid-handler returns immediately to IDLE with reset values; no redirect is issued.

## Structure
- A shared package `irq_pkg` holds the state enum (3-bit encoding) and the XLEN default.
- Single module; no sub-modules.

## Test plan
- Reset: assert rst_n=0 mid-cycle → all outputs zero, mie=RESET_MIE immediately (async).
- Basic take: mie=1, irq=1, pc_cur=0x100, isr_addr=0x2040, boundary=1 → iack at T+1; at T+2 pc_redirect with pc_target=0x2040; epc=0x100, mie=0, irq_count=1.
- Masked and blocked: mie=0 with irq=1 for 10 cycles → no iack. Then ie_set and ie_clr in the same cycle as a would-be take → no take, mie=0.
- Return: in IN_ISR, ie_set (mpie=1), then mret → pc_redirect with pc_target=0x100; mie=1 afterwards; irq held high → next iack exactly 3 cycles after mret.
- Spurious MRET: mret in IDLE → err=1 and stays 1, no pc_redirect. A second irq is still serviced normally.
- Reset mid-operation: rst_n low during REDIRECT → no further pulses, epc=0, state IDLE. After release, with irq=1 and mie forced by ie_set → clean take.
